// File: rtl/image_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_checker
//  Purpose  : Drains a DUT pixel stream and a golden reference stream from two
//             first-word-fall-through FIFOs in lockstep over a WIDTH x HEIGHT
//             frame. Counts mismatching pixels, records the first mismatch
//             location and reports how many cycles the frame took.
//  Options  : CHECKER_TOLERANCE_EN - per-channel tolerance compare plus a
//             running maximum channel difference output (max_abs_diff).
//  Revision : 1.0 - initial release
// ============================================================================
module image_stream_checker #(
    parameter int WIDTH       = 720,
    parameter int HEIGHT      = 540,
    parameter int PIXEL_BITS  = 8,
    parameter int CHANNELS    = 3,
    parameter int GRAY_EXPAND = 1,
    // Widths are clamped to one bit so that a single-column or single-row
    // frame still yields legal vector ports.
    parameter int X_BITS      = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    parameter int Y_BITS      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
`ifdef CHECKER_TOLERANCE_EN
    ,
    parameter int TOLERANCE   = 1
`endif
) (
    input  logic                                                      clock,
    input  logic                                                      reset,
    input  logic                                                      start,
    input  logic                                                      dut_empty,
    output logic                                                      dut_rd_en,
    input  logic [(GRAY_EXPAND ? PIXEL_BITS : CHANNELS*PIXEL_BITS)-1:0] dut_dout,
    input  logic                                                      ref_empty,
    output logic                                                      ref_rd_en,
    input  logic [CHANNELS*PIXEL_BITS-1:0]                            ref_dout,
    output logic                                                      busy,
    output logic                                                      done,
    output logic [31:0]                                               error_count,
    output logic                                                      first_err_valid,
    output logic [X_BITS-1:0]                                         first_err_x,
    output logic [Y_BITS-1:0]                                         first_err_y,
    output logic [31:0]                                               cycle_count
`ifdef CHECKER_TOLERANCE_EN
    ,
    output logic [PIXEL_BITS-1:0]                                     max_abs_diff
`endif
);

    localparam int              c_REF_BITS = CHANNELS * PIXEL_BITS;
    localparam logic [X_BITS-1:0] c_X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] c_Y_LAST = Y_BITS'(HEIGHT - 1);
    localparam logic [31:0]     c_SAT      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [X_BITS-1:0]     r_x;
    logic [Y_BITS-1:0]     r_y;
    logic [31:0]           r_error_count;
    logic [31:0]           r_cycle_count;
    logic                  r_first_err_valid;
    logic [X_BITS-1:0]     r_first_err_x;
    logic [Y_BITS-1:0]     r_first_err_y;

    logic                  w_pop;
    logic                  w_last;
    logic                  w_clear;
    logic                  w_mismatch;
    logic [c_REF_BITS-1:0] w_act;

    // Both FIFOs pop together, only when both heads are valid. Reset blocks
    // the pop in its own cycle so an abort leaves the FIFOs untouched.
    assign w_pop     = (r_state == S_RUN) && !dut_empty && !ref_empty && !reset;
    assign dut_rd_en = w_pop;
    assign ref_rd_en = w_pop;

    assign w_last  = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    // start is honoured in IDLE and DONE; during RUN it is ignored.
    assign w_clear = start && (r_state != S_RUN);

    // A gray DUT word is replicated across all channels before compare.
    generate
        if (GRAY_EXPAND != 0) begin : g_gray
            assign w_act = {CHANNELS{dut_dout}};
        end else begin : g_full
            assign w_act = dut_dout;
        end
    endgenerate

`ifdef CHECKER_TOLERANCE_EN
    localparam logic [PIXEL_BITS-1:0] c_TOL = PIXEL_BITS'(TOLERANCE);

    logic [PIXEL_BITS:0]   w_diff [CHANNELS];
    logic [PIXEL_BITS:0]   w_neg  [CHANNELS];
    logic [PIXEL_BITS-1:0] w_abs  [CHANNELS];
    logic [PIXEL_BITS-1:0] w_max_ch;
    logic [PIXEL_BITS-1:0] r_max_abs_diff;

    // Per-channel absolute difference using a one-bit-wider signed result.
    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            assign w_diff[ch] = {1'b0, w_act[ch*PIXEL_BITS +: PIXEL_BITS]}
                              - {1'b0, ref_dout[ch*PIXEL_BITS +: PIXEL_BITS]};
            assign w_neg[ch]  = -w_diff[ch];
            assign w_abs[ch]  = w_diff[ch][PIXEL_BITS] ? w_neg[ch][PIXEL_BITS-1:0]
                                                       : w_diff[ch][PIXEL_BITS-1:0];
        end
    endgenerate

    // Pixel fails if any channel exceeds the tolerance; also find the largest channel gap.
    always_comb begin
        w_mismatch = 1'b0;
        w_max_ch   = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (w_abs[ch] > c_TOL) begin
                w_mismatch = 1'b1;
            end
            if (w_abs[ch] > w_max_ch) begin
                w_max_ch = w_abs[ch];
            end
        end
    end

    // Running maximum channel difference over the popped pixels of the frame.
    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_max_abs_diff <= '0;
        end else if (w_pop && (w_max_ch > r_max_abs_diff)) begin
            r_max_abs_diff <= w_max_ch;
        end
    end

    assign max_abs_diff = r_max_abs_diff;
`else
    // Exact full-width compare.
    always_comb begin
        w_mismatch = (w_act != ref_dout);
    end
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_pop && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Frame position, error bookkeeping and cycle counter.
    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_x               <= '0;
            r_y               <= '0;
            r_error_count     <= '0;
            r_cycle_count     <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_x     <= '0;
            r_first_err_y     <= '0;
        end else if (r_state == S_RUN) begin
            // Every RUN cycle counts, stalled or not, including the last pop.
            if (r_cycle_count != c_SAT) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (w_pop) begin
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                if (w_mismatch) begin
                    if (r_error_count != c_SAT) begin
                        r_error_count <= r_error_count + 32'd1;
                    end
                    if (!r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_x     <= r_x;
                        r_first_err_y     <= r_y;
                    end
                end
            end
        end
    end

    assign error_count     = r_error_count;
    assign cycle_count     = r_cycle_count;
    assign first_err_valid = r_first_err_valid;
    assign first_err_x     = r_first_err_x;
    assign first_err_y     = r_first_err_y;

endmodule
`default_nettype wire

// File: tb/tb_image_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_image_stream_checker
//  Purpose  : Directed self-checking bench for image_stream_checker on a 4x2
//             gray frame, plus a 1x3 frame for the single-column case.
//             CHECKER_TOLERANCE_EN enables the tolerance scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_image_stream_checker;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
`ifdef CHECKER_TOLERANCE_EN
    localparam logic [23:0] c_BAD_REF = 24'h181818;
`else
    localparam logic [23:0] c_BAD_REF = 24'h111111;
`endif
    localparam logic [7:0]  c_BAD_DUT = 8'h10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall_ref = 1'b0;

    // FWFT FIFO models
    logic [7:0]  dut_mem [64];
    logic [23:0] ref_mem [64];
    logic [5:0]  dut_wp = '0, dut_rp = '0;
    logic [5:0]  ref_wp = '0, ref_rp = '0;

    logic        dut_empty, ref_empty, dut_rd_en, ref_rd_en;
    logic [7:0]  dut_dout;
    logic [23:0] ref_dout;
    logic        busy, done, first_err_valid;
    logic [31:0] error_count, cycle_count;
    logic [1:0]  first_err_x;
    logic        first_err_y;
`ifdef CHECKER_TOLERANCE_EN
    logic [7:0]  max_abs_diff;
`endif

    // Single-column instance signals
    logic        w1_start = 1'b0;
    logic        w1_empty = 1'b1;
    logic [7:0]  w1_dut = 8'h05;
    logic [23:0] w1_ref = 24'h050505;
    logic        w1_dut_rd_en, w1_ref_rd_en, w1_busy, w1_done, w1_fev;
    logic [31:0] w1_err, w1_cyc;
    logic        w1_fx;
    logic [1:0]  w1_fy;
`ifdef CHECKER_TOLERANCE_EN
    logic [7:0]  w1_max;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    assign dut_empty = (dut_wp == dut_rp);
    assign ref_empty = (ref_wp == ref_rp) || stall_ref;
    assign dut_dout  = dut_mem[dut_rp];
    assign ref_dout  = ref_mem[ref_rp];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dut_rd_en) dut_rp <= dut_rp + 6'd1;
        if (ref_rd_en) ref_rp <= ref_rp + 6'd1;
    end

    image_stream_checker #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_BITS(8), .CHANNELS(3), .GRAY_EXPAND(1)
`ifdef CHECKER_TOLERANCE_EN
        , .TOLERANCE(1)
`endif
    ) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .dut_empty(dut_empty), .dut_rd_en(dut_rd_en), .dut_dout(dut_dout),
        .ref_empty(ref_empty), .ref_rd_en(ref_rd_en), .ref_dout(ref_dout),
        .busy(busy), .done(done), .error_count(error_count),
        .first_err_valid(first_err_valid), .first_err_x(first_err_x),
        .first_err_y(first_err_y), .cycle_count(cycle_count)
`ifdef CHECKER_TOLERANCE_EN
        , .max_abs_diff(max_abs_diff)
`endif
    );

    image_stream_checker #(
        .WIDTH(1), .HEIGHT(3), .PIXEL_BITS(8), .CHANNELS(3), .GRAY_EXPAND(1)
    ) u_w1 (
        .clock(clock), .reset(reset), .start(w1_start),
        .dut_empty(w1_empty), .dut_rd_en(w1_dut_rd_en), .dut_dout(w1_dut),
        .ref_empty(w1_empty), .ref_rd_en(w1_ref_rd_en), .ref_dout(w1_ref),
        .busy(w1_busy), .done(w1_done), .error_count(w1_err),
        .first_err_valid(w1_fev), .first_err_x(w1_fx),
        .first_err_y(w1_fy), .cycle_count(w1_cyc)
`ifdef CHECKER_TOLERANCE_EN
        , .max_abs_diff(w1_max)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [23:0] r);
        dut_mem[dut_wp] = d;
        ref_mem[ref_wp] = r;
        dut_wp = dut_wp + 6'd1;
        ref_wp = ref_wp + 6'd1;
    endtask

    // Eight-pixel frame; pixel bad_idx (if in range) carries the known mismatch.
    task automatic load_frame(input int bad_idx);
        logic [7:0] d;
        for (int p = 0; p < 8; p++) begin
            d = 8'h20 + 8'(p * 3);
            if (p == bad_idx) push(c_BAD_DUT, c_BAD_REF);
            else              push(d, {3{d}});
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [5:0] rp_save;

        // ---------------- reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_rd_en", {31'd0, dut_rd_en}, 32'd0);
        check("rst_err",   error_count, 32'd0);
        check("rst_cyc",   cycle_count, 32'd0);
        check("rst_fev",   {31'd0, first_err_valid}, 32'd0);

        // ---------------- exact-match frame
        load_frame(-1);
        tick();
        check("idle_no_pop", {31'd0, dut_rd_en}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("run_busy",   {31'd0, busy}, 32'd1);
        check("run_pop0",   {31'd0, dut_rd_en & ref_rd_en}, 32'd1);
        check("run_cyc0",   cycle_count, 32'd0);
        for (int i = 0; i < 7; i++) tick();
        check("m_done_pre7", {31'd0, done}, 32'd0);
        tick();
        check("m_done",  {31'd0, done}, 32'd1);
        check("m_busy",  {31'd0, busy}, 32'd0);
        check("m_err",   error_count, 32'd0);
        check("m_fev",   {31'd0, first_err_valid}, 32'd0);
        check("m_cyc",   cycle_count, 32'd8);
        check("m_rd_en", {31'd0, dut_rd_en}, 32'd0);

        // ---------------- restart from DONE, mismatch at pixel 6, start during RUN ignored
        load_frame(6);
        tick();
        check("done_hold_cyc", cycle_count, 32'd8);
        start = 1'b1; tick(); start = 1'b0;
        check("rs_cyc_clr", cycle_count, 32'd0);
        check("rs_busy",    {31'd0, busy}, 32'd1);
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        check("rs_ign_busy", {31'd0, busy}, 32'd1);
        check("rs_ign_cyc",  cycle_count, 32'd3);
        wait_done(20);
        check("mm_err", error_count, 32'd1);
        check("mm_fev", {31'd0, first_err_valid}, 32'd1);
        check("mm_fx",  {30'd0, first_err_x}, 32'd2);
        check("mm_fy",  {31'd0, first_err_y}, 32'd1);
        check("mm_cyc", cycle_count, 32'd8);

        // ---------------- five-cycle reference stall mid-frame
        load_frame(6);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        stall_ref = 1'b1;
        rp_save = dut_rp;
        for (int i = 0; i < 4; i++) tick();
        check("st_rd_en", {31'd0, dut_rd_en | ref_rd_en}, 32'd0);
        tick();
        check("st_no_pop", {26'd0, dut_rp}, {26'd0, rp_save});
        check("st_err_hold", error_count, 32'd0);
        stall_ref = 1'b0;
        wait_done(20);
        check("st_cyc", cycle_count, 32'd13);
        check("st_err", error_count, 32'd1);
        check("st_fx",  {30'd0, first_err_x}, 32'd2);

        // ---------------- reset mid-frame, then fresh frame
        load_frame(0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        check("ab_err_pre", error_count, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("ab_busy",  {31'd0, busy}, 32'd0);
        check("ab_rd_en", {31'd0, dut_rd_en | ref_rd_en}, 32'd0);
        check("ab_err",   error_count, 32'd0);
        check("ab_cyc",   cycle_count, 32'd0);
        check("ab_fev",   {31'd0, first_err_valid}, 32'd0);
        dut_wp = dut_rp;
        ref_wp = ref_rp;
        load_frame(3);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(20);
        check("ab2_err", error_count, 32'd1);
        check("ab2_fx",  {30'd0, first_err_x}, 32'd3);
        check("ab2_fy",  {31'd0, first_err_y}, 32'd0);
        check("ab2_cyc", cycle_count, 32'd8);

        // ---------------- reset and start together: reset wins
        load_frame(-1);
        reset = 1'b1; start = 1'b1; tick();
        reset = 1'b0; start = 1'b0;
        check("rs_st_busy", {31'd0, busy}, 32'd0);
        check("rs_st_done", {31'd0, done}, 32'd0);
        check("rs_st_err",  error_count, 32'd0);
        tick();
        check("rs_st_idle", {31'd0, busy}, 32'd0);

`ifdef CHECKER_TOLERANCE_EN
        // ---------------- tolerance compare (buffered frame already loaded above)
        dut_wp = dut_rp;
        ref_wp = ref_rp;
        push(8'h41, 24'h404040);
        push(8'h43, 24'h404040);
        for (int p = 2; p < 8; p++) push(8'h30, 24'h303030);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(20);
        check("tol_err", error_count, 32'd1);
        check("tol_fx",  {30'd0, first_err_x}, 32'd1);
        check("tol_fy",  {31'd0, first_err_y}, 32'd0);
        check("tol_max", {24'd0, max_abs_diff}, 32'd3);
`endif

        // ---------------- single-column frame: y steps on every pop
        w1_empty = 1'b0;
        w1_start = 1'b1; tick(); w1_start = 1'b0;
        check("w1_busy", {31'd0, w1_busy}, 32'd1);
        tick();
        w1_ref = 24'h505050;
        tick();
        w1_ref = 24'h050505;
        check("w1_run", {31'd0, w1_busy}, 32'd1);
        tick();
        w1_empty = 1'b1;
        check("w1_done", {31'd0, w1_done}, 32'd1);
        check("w1_err",  w1_err, 32'd1);
        check("w1_fx",   {31'd0, w1_fx}, 32'd0);
        check("w1_fy",   {30'd0, w1_fy}, 32'd1);
        check("w1_cyc",  w1_cyc, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
